btb_update_sched: RTL and testbench

Write-port scheduler for the 2-way branch target buffer. It accepts target updates from two pipeline requesters: ID-stage decode of jumps/branches and EX-stage resolved corrections. Updates are buffered in a small in-order queue, coalesced when they name the same pc, and issued one per cycle on the BTB write port (write, ID_pc mux leg, pc_imm_in, ID_Branch). A flush sequencer discards pending updates and drives a timed synchronous clear of the BTB.

---
 rtl/btb_update_sched.sv | 206 ++++++++++++++++++++
 tb/tb_btb_update_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_sched.sv
// btb_update_sched: write-port scheduler for the 2-way branch target buffer.
// Buffers target updates from the EX (resolved corrections) and ID (decode)
// requesters in a small in-order queue and issues one BTB write per cycle.
// A flush sequencer empties the queue and drives a timed BTB clear.
//
// Optional feature macro: BTB_SCHED_COALESCE_EN
//   defined   - an accepted request whose pc matches a queued entry updates
//               that entry in place; same-pc EX/ID pairs form one entry (EX wins)
//   undefined - every accepted request takes its own slot
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ex_req_* / id_req_*             EX / ID update handshakes (pc, target, branch)
//   wr_hold                         suppresses issue this cycle
//   flush_req                       starts a flush when seen in IDLE
//   btb_write/btb_pc/btb_imm/btb_branch  registered BTB write port
//   btb_clr_n                       registered active-low BTB clear
//   flush_done                      one-cycle pulse at flush completion
//   busy                            queue non-empty or flush in progress
//   q_count                         occupied queue entries
module btb_update_sched #(
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned CLR_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ex_req_valid,
    output logic                        ex_req_ready,
    input  logic [31:0]                 ex_req_pc,
    input  logic [31:0]                 ex_req_target,
    input  logic                        ex_req_branch,
    input  logic                        id_req_valid,
    output logic                        id_req_ready,
    input  logic [31:0]                 id_req_pc,
    input  logic [31:0]                 id_req_target,
    input  logic                        id_req_branch,
    input  logic                        wr_hold,
    input  logic                        flush_req,
    output logic                        btb_write,
    output logic [31:0]                 btb_pc,
    output logic [31:0]                 btb_imm,
    output logic                        btb_branch,
    output logic                        btb_clr_n,
    output logic                        flush_done,
    output logic                        busy,
    output logic [$clog2(QDEPTH+1)-1:0] q_count
);
    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned KW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        branch;
    } upd_t;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] clr_cnt_q, clr_cnt_d;
    logic          clr_n_d, done_d;

    upd_t          mem [QDEPTH];
    upd_t          ex_ent, id_ent;
    logic [AW-1:0] head_q, tail, id_slot;
    logic [CW-1:0] count_q, free;
    logic          pop, ex_acc, id_acc;
    logic          ex_push, id_push, ex_ovr, id_ovr;
    logic [AW-1:0] ex_idx, id_idx;

    assign ex_ent = '{pc: ex_req_pc, target: ex_req_target, branch: ex_req_branch};
    assign id_ent = '{pc: id_req_pc, target: id_req_target, branch: id_req_branch};

    // Acceptance uses occupancy only; a pop in the same cycle is not credited.
    assign free         = CW'(QDEPTH) - count_q;
    assign ex_req_ready = (state_q == IDLE) && !flush_req && (free >= CW'(1));
    assign id_req_ready = (state_q == IDLE) && !flush_req &&
                          ((free >= CW'(2)) || ((free >= CW'(1)) && !ex_req_valid));
    assign ex_acc       = ex_req_valid && ex_req_ready;
    assign id_acc       = id_req_valid && id_req_ready;

    assign pop     = (state_q == IDLE) && !flush_req && !wr_hold && (count_q != '0);
    assign tail    = head_q + AW'(count_q);
    assign id_slot = ex_push ? (tail + AW'(1)) : tail;
    assign busy    = (count_q != '0) || (state_q != IDLE);
    assign q_count = count_q;

`ifdef BTB_SCHED_COALESCE_EN
    logic          ex_hit, id_hit, same_pc;
    logic [AW-1:0] off;
    logic          live;

    // Search occupied entries for a pc match; the head being popped is excluded.
    always_comb begin
        ex_hit = 1'b0;
        id_hit = 1'b0;
        ex_idx = '0;
        id_idx = '0;
        off    = '0;
        live   = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            off  = AW'(i) - head_q;
            live = (CW'(off) < count_q) && !(pop && (AW'(i) == head_q));
            if (live && (mem[i].pc == ex_req_pc)) begin
                ex_hit = 1'b1;
                ex_idx = AW'(i);
            end
            if (live && (mem[i].pc == id_req_pc)) begin
                id_hit = 1'b1;
                id_idx = AW'(i);
            end
        end
    end

    // A same-pc EX/ID pair collapses onto the EX request.
    assign same_pc = ex_acc && id_acc && (ex_req_pc == id_req_pc);
    assign ex_push = ex_acc && !ex_hit;
    assign ex_ovr  = ex_acc && ex_hit;
    assign id_push = id_acc && !id_hit && !same_pc;
    assign id_ovr  = id_acc && id_hit && !same_pc;
`else
    assign ex_push = ex_acc;
    assign id_push = id_acc;
    assign ex_ovr  = 1'b0;
    assign id_ovr  = 1'b0;
    assign ex_idx  = '0;
    assign id_idx  = '0;
`endif

    // Queue storage: EX lands before ID; overwrites target distinct live slots.
    always_ff @(posedge clk) begin
        if (ex_push) mem[tail]    <= ex_ent;
        if (id_push) mem[id_slot] <= id_ent;
        if (ex_ovr)  mem[ex_idx]  <= ex_ent;
        if (id_ovr)  mem[id_idx]  <= id_ent;
    end

    // Queue pointers; a flush start empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            count_q <= '0;
        end else if ((state_q == IDLE) && flush_req) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) head_q <= head_q + AW'(1);
            count_q <= count_q + CW'(ex_push) + CW'(id_push) - CW'(pop);
        end
    end

    // BTB write port: data holds its last value when no write issues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btb_write  <= 1'b0;
            btb_pc     <= '0;
            btb_imm    <= '0;
            btb_branch <= 1'b0;
        end else begin
            btb_write <= pop;
            if (pop) begin
                btb_pc     <= mem[head_q].pc;
                btb_imm    <= mem[head_q].target;
                btb_branch <= mem[head_q].branch;
            end
        end
    end

    // Flush FSM state register and registered clear/done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            btb_clr_n  <= 1'b1;
            flush_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            btb_clr_n  <= clr_n_d;
            flush_done <= done_d;
        end
    end

    // Flush FSM next state; outputs follow the state being entered.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == KW'(CLR_CYCLES - 1)) state_d = DONE;
                else clr_cnt_d = clr_cnt_q + KW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_n_d = (state_d != CLEAR);
        done_d  = (state_d == DONE);
    end
endmodule

// File: tb/tb_btb_update_sched.sv
// Directed self-checking bench for btb_update_sched (QDEPTH=4, CLR_CYCLES=2).
// Expectations follow BTB_SCHED_COALESCE_EN when it is defined.
module tb_btb_update_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_req_valid, ex_req_ready, ex_req_branch;
    logic [31:0] ex_req_pc, ex_req_target;
    logic        id_req_valid, id_req_ready, id_req_branch;
    logic [31:0] id_req_pc, id_req_target;
    logic        wr_hold, flush_req;
    logic        btb_write, btb_branch, btb_clr_n, flush_done, busy;
    logic [31:0] btb_pc, btb_imm;
    logic [2:0]  q_count;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BTB_SCHED_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    btb_update_sched #(.QDEPTH(4), .CLR_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready),
        .ex_req_pc(ex_req_pc), .ex_req_target(ex_req_target), .ex_req_branch(ex_req_branch),
        .id_req_valid(id_req_valid), .id_req_ready(id_req_ready),
        .id_req_pc(id_req_pc), .id_req_target(id_req_target), .id_req_branch(id_req_branch),
        .wr_hold(wr_hold), .flush_req(flush_req),
        .btb_write(btb_write), .btb_pc(btb_pc), .btb_imm(btb_imm), .btb_branch(btb_branch),
        .btb_clr_n(btb_clr_n), .flush_done(flush_done), .busy(busy), .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_req_valid = 1'b0; id_req_valid = 1'b0; wr_hold = 1'b0; flush_req = 1'b0;
        ex_req_pc = '0; ex_req_target = '0; ex_req_branch = 1'b0;
        id_req_pc = '0; id_req_target = '0; id_req_branch = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        n_checks++; if (btb_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%0h exp=0", btb_write); end
        n_checks++; if (btb_pc !== 32'h0 || btb_imm !== 32'h0 || btb_branch !== 1'b0) begin n_fail++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0/0/0", btb_pc, btb_imm, btb_branch); end
        n_checks++; if (btb_clr_n !== 1'b1 || flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush got clr_n=%0h done=%0h exp 1/0", btb_clr_n, flush_done); end
        n_checks++; if (q_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_queue got cnt=%0d busy=%0h exp 0/0", q_count, busy); end
    endtask

    task automatic test_single();
        id_req_valid = 1'b1; id_req_pc = 32'h40; id_req_target = 32'h80; id_req_branch = 1'b1;
        #1;
        n_checks++; if (id_req_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%0h exp=1", id_req_ready); end
        tick();
        id_req_valid = 1'b0;
        n_checks++; if (btb_write !== 1'b0 || q_count !== 3'd1) begin n_fail++; $display("FAIL single_c1 got wr=%0h cnt=%0d exp 0/1", btb_write, q_count); end
        tick();
        n_checks++; if (btb_write !== 1'b1 || btb_pc !== 32'h40 || btb_imm !== 32'h80 || btb_branch !== 1'b1)
            begin n_fail++; $display("FAIL single_write got %0h/%0h/%0h/%0h exp 1/40/80/1", btb_write, btb_pc, btb_imm, btb_branch); end
        tick();
        n_checks++; if (btb_write !== 1'b0 || btb_pc !== 32'h40) begin n_fail++; $display("FAIL single_hold got wr=%0h pc=%0h exp 0/40", btb_write, btb_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc [4];
        logic [31:0] exp_imm [4];
        exp_pc[0] = 32'h10; exp_pc[1] = 32'h20; exp_pc[2] = 32'h30; exp_pc[3] = 32'h50;
        exp_imm[0] = 32'h14; exp_imm[1] = 32'h24; exp_imm[2] = 32'h34; exp_imm[3] = 32'h54;
        wr_hold = 1'b1;
        ex_req_valid = 1'b1; ex_req_pc = 32'h10; ex_req_target = 32'h14; ex_req_branch = 1'b0;
        id_req_valid = 1'b1; id_req_pc = 32'h20; id_req_target = 32'h24; id_req_branch = 1'b1;
        #1;
        n_checks++; if (ex_req_ready !== 1'b1 || id_req_ready !== 1'b1) begin n_fail++; $display("FAIL dual_ready1 got %0h/%0h exp 1/1", ex_req_ready, id_req_ready); end
        tick();
        n_checks++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL dual_cnt2 got=%0d exp=2", q_count); end
        ex_req_pc = 32'h30; ex_req_target = 32'h34; ex_req_branch = 1'b1;
        id_req_pc = 32'h50; id_req_target = 32'h54; id_req_branch = 1'b0;
        #1;
        n_checks++; if (ex_req_ready !== 1'b1 || id_req_ready !== 1'b1) begin n_fail++; $display("FAIL dual_ready2 got %0h/%0h exp 1/1", ex_req_ready, id_req_ready); end
        tick();
        id_req_valid = 1'b0;
        #1;
        n_checks++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL dual_cnt4 got=%0d exp=4", q_count); end
        n_checks++; if (ex_req_ready !== 1'b0 || id_req_ready !== 1'b0) begin n_fail++; $display("FAIL dual_full_ready got %0h/%0h exp 0/0", ex_req_ready, id_req_ready); end
        ex_req_valid = 1'b0;
        wr_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (btb_write !== 1'b1 || btb_pc !== exp_pc[k] || btb_imm !== exp_imm[k] || btb_branch !== k[0] ^ 1'b0 && 1'b0 || btb_branch !== ((k == 1 || k == 2) ? 1'b1 : 1'b0))
                begin n_fail++; $display("FAIL dual_drain%0d got %0h/%0h/%0h/%0h exp 1/%0h/%0h", k, btb_write, btb_pc, btb_imm, btb_branch, exp_pc[k], exp_imm[k]); end
        end
        tick();
        n_checks++; if (btb_write !== 1'b0 || q_count !== 3'd0) begin n_fail++; $display("FAIL dual_empty got wr=%0h cnt=%0d exp 0/0", btb_write, q_count); end
    endtask

    task automatic test_coalesce();
        // Same pc enqueued twice from ID while held.
        wr_hold = 1'b1;
        id_req_valid = 1'b1; id_req_pc = 32'h100; id_req_target = 32'h200; id_req_branch = 1'b0;
        tick();
        id_req_target = 32'h300; id_req_branch = 1'b1;
        tick();
        id_req_valid = 1'b0;
        n_checks++; if (q_count !== (COAL ? 3'd1 : 3'd2)) begin n_fail++; $display("FAIL coal_cnt got=%0d exp=%0d", q_count, COAL ? 1 : 2); end
        wr_hold = 1'b0;
        tick();
        n_checks++; if (btb_write !== 1'b1 || btb_pc !== 32'h100 || btb_imm !== (COAL ? 32'h300 : 32'h200))
            begin n_fail++; $display("FAIL coal_w1 got %0h/%0h/%0h exp 1/100/%0h", btb_write, btb_pc, btb_imm, COAL ? 32'h300 : 32'h200); end
        tick();
        n_checks++; if (btb_write !== (COAL ? 1'b0 : 1'b1) || btb_imm !== 32'h300 || btb_branch !== 1'b1)
            begin n_fail++; $display("FAIL coal_w2 got %0h/%0h/%0h exp %0h/300/1", btb_write, btb_imm, btb_branch, COAL ? 0 : 1); end
        tick();
        // Same pc from EX and ID in one cycle: EX data wins when merged.
        wr_hold = 1'b1;
        ex_req_valid = 1'b1; ex_req_pc = 32'h700; ex_req_target = 32'h111; ex_req_branch = 1'b1;
        id_req_valid = 1'b1; id_req_pc = 32'h700; id_req_target = 32'h222; id_req_branch = 1'b0;
        tick();
        ex_req_valid = 1'b0; id_req_valid = 1'b0;
        n_checks++; if (q_count !== (COAL ? 3'd1 : 3'd2)) begin n_fail++; $display("FAIL pair_cnt got=%0d exp=%0d", q_count, COAL ? 1 : 2); end
        wr_hold = 1'b0;
        tick();
        n_checks++; if (btb_write !== 1'b1 || btb_imm !== 32'h111 || btb_branch !== 1'b1)
            begin n_fail++; $display("FAIL pair_w1 got %0h/%0h/%0h exp 1/111/1", btb_write, btb_imm, btb_branch); end
        tick();
        n_checks++; if (btb_write !== (COAL ? 1'b0 : 1'b1) || btb_imm !== (COAL ? 32'h111 : 32'h222))
            begin n_fail++; $display("FAIL pair_w2 got %0h/%0h exp %0h/%0h", btb_write, btb_imm, COAL ? 0 : 1, COAL ? 32'h111 : 32'h222); end
        tick();
        // Match against the head being popped this cycle must enqueue normally.
        wr_hold = 1'b1;
        id_req_valid = 1'b1; id_req_pc = 32'h900; id_req_target = 32'hA00; id_req_branch = 1'b0;
        tick();
        wr_hold = 1'b0; id_req_target = 32'hB00; id_req_branch = 1'b1;
        tick();
        id_req_valid = 1'b0;
        n_checks++; if (btb_write !== 1'b1 || btb_imm !== 32'hA00 || q_count !== 3'd1)
            begin n_fail++; $display("FAIL head_w1 got %0h/%0h cnt=%0d exp 1/a00 cnt=1", btb_write, btb_imm, q_count); end
        tick();
        n_checks++; if (btb_write !== 1'b1 || btb_imm !== 32'hB00 || btb_branch !== 1'b1 || q_count !== 3'd0)
            begin n_fail++; $display("FAIL head_w2 got %0h/%0h/%0h cnt=%0d exp 1/b00/1 cnt=0", btb_write, btb_imm, btb_branch, q_count); end
        tick();
    endtask

    task automatic test_flush();
        wr_hold = 1'b1;
        ex_req_valid = 1'b1; ex_req_pc = 32'h1000; ex_req_target = 32'h1; ex_req_branch = 1'b0;
        id_req_valid = 1'b1; id_req_pc = 32'h2000; id_req_target = 32'h2; id_req_branch = 1'b0;
        tick();
        ex_req_valid = 1'b0; id_req_pc = 32'h3000; id_req_target = 32'h3;
        tick();
        n_checks++; if (q_count !== 3'd3) begin n_fail++; $display("FAIL flush_fill got=%0d exp=3", q_count); end
        // flush_req with a valid ID request in the same cycle.
        id_req_pc = 32'hAAA0; flush_req = 1'b1; wr_hold = 1'b0;
        #1;
        n_checks++; if (id_req_ready !== 1'b0 || ex_req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_req_ready got %0h/%0h exp 0/0", ex_req_ready, id_req_ready); end
        tick();
        flush_req = 1'b0;
        n_checks++; if (btb_clr_n !== 1'b0 || q_count !== 3'd0 || btb_write !== 1'b0 || id_req_ready !== 1'b0 || flush_done !== 1'b0)
            begin n_fail++; $display("FAIL flush_clr1 got clr_n=%0h cnt=%0d wr=%0h rdy=%0h done=%0h exp 0/0/0/0/0", btb_clr_n, q_count, btb_write, id_req_ready, flush_done); end
        tick();
        n_checks++; if (btb_clr_n !== 1'b0 || btb_write !== 1'b0 || id_req_ready !== 1'b0 || flush_done !== 1'b0)
            begin n_fail++; $display("FAIL flush_clr2 got clr_n=%0h wr=%0h rdy=%0h done=%0h exp 0/0/0/0", btb_clr_n, btb_write, id_req_ready, flush_done); end
        tick();
        n_checks++; if (btb_clr_n !== 1'b1 || flush_done !== 1'b1 || id_req_ready !== 1'b0 || btb_write !== 1'b0 || busy !== 1'b1)
            begin n_fail++; $display("FAIL flush_done got clr_n=%0h done=%0h rdy=%0h wr=%0h busy=%0h exp 1/1/0/0/1", btb_clr_n, flush_done, id_req_ready, btb_write, busy); end
        tick();
        n_checks++; if (flush_done !== 1'b0 || q_count !== 3'd0 || btb_write !== 1'b0 || id_req_ready !== 1'b1 || busy !== 1'b0)
            begin n_fail++; $display("FAIL flush_idle got done=%0h cnt=%0d wr=%0h rdy=%0h busy=%0h exp 0/0/0/1/0", flush_done, q_count, btb_write, id_req_ready, busy); end
        id_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n_checks++; if (btb_clr_n !== 1'b0) begin n_fail++; $display("FAIL rflush_clear got=%0h exp=0", btb_clr_n); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (btb_clr_n !== 1'b1 || flush_done !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rflush_reset got clr_n=%0h done=%0h busy=%0h exp 1/0/0", btb_clr_n, flush_done, busy); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (flush_done !== 1'b0 || btb_clr_n !== 1'b1 || ex_req_ready !== 1'b1)
                begin n_fail++; $display("FAIL rflush_after%0d got done=%0h clr_n=%0h rdy=%0h exp 0/1/1", k, flush_done, btb_clr_n, ex_req_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_coalesce();
        test_flush();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
